serial_stuff_tx: RTL and testbench

- Serial transmitter that produces the single-bit stream consumed by our run-detector FSMs.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Inserts a complement "stuff" bit whenever MAX_RUN identical bits have been sent in a row, so the line never carries a run longer than MAX_RUN.
- Sits between the test/stimulus logic and any downstream bit-level receiver.

---
 rtl/serial_tx_pkg.sv | 26 ++
 rtl/run_tracker.sv | 54 +++++
 rtl/serial_stuff_tx.sv | 183 ++++++++++++++++++
 tb/tb_serial_stuff_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial_stuff_tx transmitter slice.
//
// Contents:
//   tx_state_t       transmitter FSM states. PARITY is always declared so
//                    the encoding is stable whether or not the parity option
//                    (macro SERIAL_STUFF_TX_PARITY_EN) is compiled in.
//   DEFAULT_WIDTH    default data word width
//   DEFAULT_MAX_RUN  default longest permitted run of identical line bits
//   run_width()      width of a counter able to hold 0..max_run
package serial_tx_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_MAX_RUN = 5;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        STUFF,
        PARITY
    } tx_state_t;

    function automatic int run_width(input int max_run);
        return $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/run_tracker.sv
// Tracks the length of the current run of identical line bits.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   clear      drop all run history (run = 0, last_bit = 0)
//   bit_valid  bit_in is a line bit being launched this cycle
//   bit_in     value of that line bit
//   last_bit   value of the most recently tracked bit
//   stuff_req  run has reached MAX_RUN; the next line bit must be a stuff bit
//
// The caller feeds this block the bit it is about to register onto the line.
// That way the run count already includes the bit now on the line, and the
// caller can decide the following bit in the same cycle.
module run_tracker
    import serial_tx_pkg::*;
#(
    parameter int MAX_RUN = DEFAULT_MAX_RUN
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    output logic last_bit,
    output logic stuff_req
);

    localparam int RUN_W = run_width(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [RUN_W-1:0] run;

    // The count saturates at MAX_RUN. That only matters when MAX_RUN is 1:
    // a data bit that matches the preceding stuff bit must still read as a
    // full run, so that it also gets a stuff bit after it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            run      <= '0;
            last_bit <= 1'b0;
        end else if (bit_valid) begin
            if (run == '0 || bit_in != last_bit) begin
                run <= RUN_ONE;
            end else if (run != RUN_MAX) begin
                run <= run + RUN_ONE;
            end
            last_bit <= bit_in;
        end
    end

    assign stuff_req = (run == RUN_MAX);

endmodule

// File: rtl/serial_stuff_tx.sv
// Bit-stuffing serial transmitter.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// MSB-first, one bit per clock. After MAX_RUN identical line bits it inserts
// a complement stuff bit, so no run on the line is longer than MAX_RUN.
//
// Optional feature: define SERIAL_STUFF_TX_PARITY_EN to append an even-parity
// bit over the data bits. The parity bit takes part in run tracking and can
// trigger one trailing stuff bit.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   parallel word offered
//   in_data    word to transmit, MSB first
//   in_ready   block can accept a word this cycle (combinational: state==IDLE)
//   out_valid  out_bit carries a line bit this cycle
//   out_bit    serial line bit
//   out_stuff  current out_bit is an inserted stuff bit
//   busy       frame in progress
//
// The registered state names the kind of bit now on the line. The next bit
// is decided combinationally and registered together with its state.
module serial_stuff_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MAX_RUN = DEFAULT_MAX_RUN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_stuff,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    tx_state_t        state;
    tx_state_t        next_state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] next_shreg;
    logic [CNT_W-1:0] bits_left;
    logic [CNT_W-1:0] next_bits_left;
    logic             next_valid;
    logic             next_bit;
    logic             next_stuff;
    logic             last_bit;
    logic             stuff_req;
    logic             tracker_clear;

`ifdef SERIAL_STUFF_TX_PARITY_EN
    logic             parity;
    logic             next_parity;
    logic             parity_done;
    logic             next_parity_done;
`endif

    assign in_ready = (state == IDLE);

    // Leaving for IDLE wipes the run history, so every frame starts fresh.
    assign tracker_clear = (next_state == IDLE);

    run_tracker #(
        .MAX_RUN (MAX_RUN)
    ) u_run_tracker (
        .clk       (clk),
        .reset     (reset),
        .clear     (tracker_clear),
        .bit_valid (next_valid),
        .bit_in    (next_bit),
        .last_bit  (last_bit),
        .stuff_req (stuff_req)
    );

    // Next-bit selection. bits_left counts the data bits not yet launched,
    // and shreg holds those bits MSB-aligned. A stuff bit is never followed
    // by another stuff bit; with MAX_RUN=1 the saturated run count would
    // otherwise keep requesting stuff bits forever.
    always_comb begin
        next_state     = state;
        next_shreg     = shreg;
        next_bits_left = bits_left;
        next_valid     = 1'b0;
        next_bit       = 1'b0;
        next_stuff     = 1'b0;
`ifdef SERIAL_STUFF_TX_PARITY_EN
        next_parity      = parity;
        next_parity_done = parity_done;
`endif

        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state     = SEND;
                    next_valid     = 1'b1;
                    next_bit       = in_data[WIDTH-1];
                    next_shreg     = in_data << 1;
                    next_bits_left = CNT_W'(WIDTH - 1);
`ifdef SERIAL_STUFF_TX_PARITY_EN
                    next_parity      = ^in_data;
                    next_parity_done = 1'b0;
`endif
                end
            end

            SEND, STUFF: begin
                if (state == SEND && stuff_req) begin
                    next_state = STUFF;
                    next_valid = 1'b1;
                    next_bit   = ~last_bit;
                    next_stuff = 1'b1;
                end else if (bits_left != '0) begin
                    next_state     = SEND;
                    next_valid     = 1'b1;
                    next_bit       = shreg[WIDTH-1];
                    next_shreg     = shreg << 1;
                    next_bits_left = bits_left - CNT_ONE;
`ifdef SERIAL_STUFF_TX_PARITY_EN
                end else if (!parity_done) begin
                    next_state       = PARITY;
                    next_valid       = 1'b1;
                    next_bit         = parity;
                    next_parity_done = 1'b1;
`endif
                end else begin
                    next_state = IDLE;
                end
            end

`ifdef SERIAL_STUFF_TX_PARITY_EN
            PARITY: begin
                if (stuff_req) begin
                    next_state = STUFF;
                    next_valid = 1'b1;
                    next_bit   = ~last_bit;
                    next_stuff = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
`endif

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bits_left <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_stuff <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_STUFF_TX_PARITY_EN
            parity      <= 1'b0;
            parity_done <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            shreg     <= next_shreg;
            bits_left <= next_bits_left;
            out_valid <= next_valid;
            out_bit   <= next_bit;
            out_stuff <= next_stuff;
            busy      <= (next_state != IDLE);
`ifdef SERIAL_STUFF_TX_PARITY_EN
            parity      <= next_parity;
            parity_done <= next_parity_done;
`endif
        end
    end

endmodule

// File: tb/tb_serial_stuff_tx.sv
// Self-checking bench for serial_stuff_tx.
//
// Three instances run side by side: MAX_RUN=5 (index 0), MAX_RUN=2 (index 1)
// and MAX_RUN=1 (index 2). Only one instance is driven at a time. Stimulus
// pushes the hand-computed line bits, tagged with the instance index, into
// one queue. A negedge monitor pops an entry for every out_valid bit and
// compares it. Expected frames include the parity bit when
// SERIAL_STUFF_TX_PARITY_EN is defined.
module tb_serial_stuff_tx;

    typedef struct {
        int   inst;
        logic b;
        logic s;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [2:0] in_valid;
    logic [7:0] in_data;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] out_bit;
    logic [2:0] out_stuff;
    logic [2:0] busy;

    exp_t exp_q[$];
    int   hs_count[3];
    int   checks;
    int   failures;

    serial_stuff_tx #(.WIDTH(8), .MAX_RUN(5)) u_run5 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data),
        .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_bit(out_bit[0]),
        .out_stuff(out_stuff[0]), .busy(busy[0])
    );

    serial_stuff_tx #(.WIDTH(8), .MAX_RUN(2)) u_run2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data),
        .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_bit(out_bit[1]),
        .out_stuff(out_stuff[1]), .busy(busy[1])
    );

    serial_stuff_tx #(.WIDTH(8), .MAX_RUN(1)) u_run1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_data(in_data),
        .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_bit(out_bit[2]),
        .out_stuff(out_stuff[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Handshakes counted on the edge that accepts them.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset && in_valid[k] && in_ready[k]) hs_count[k]++;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (out_valid[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected bit on u%0d: got %0b expected none at %0t",
                             k, out_bit[k], $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("line bit instance", k, e.inst);
                    checkOutput($sformatf("u%0d out_bit", k), {31'b0, out_bit[k]}, {31'b0, e.b});
                    checkOutput($sformatf("u%0d out_stuff", k), {31'b0, out_stuff[k]}, {31'b0, e.s});
                    checkOutput($sformatf("u%0d busy in frame", k), {31'b0, busy[k]}, 32'd1);
                end
            end
        end
    end

    task automatic pushFrame(input int k, input logic [31:0] bits,
                             input logic [31:0] stuffs, input int n);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            e.inst = k;
            e.b    = bits[i];
            e.s    = stuffs[i];
            exp_q.push_back(e);
        end
    endtask

    // Steps cycle by cycle until the monitor has consumed every expected bit,
    // checking that out_valid never drops in between.
    task automatic waitDrain(input int k);
        int guard;
        guard = 0;
        while (1) begin
            checkOutput($sformatf("u%0d out_valid contiguous", k), {31'b0, out_valid[k]}, 32'd1);
            if (exp_q.size() == 0) break;
            guard++;
            if (guard > 64) begin
                checks++;
                failures++;
                $display("[TB] FAIL u%0d frame timeout: got %0d bits pending expected 0",
                         k, exp_q.size());
                exp_q.delete();
                break;
            end
            tick();
        end
    endtask

    task automatic checkIdle(input int k);
        checkOutput($sformatf("u%0d idle out_valid", k), {31'b0, out_valid[k]}, 32'd0);
        checkOutput($sformatf("u%0d idle out_bit", k), {31'b0, out_bit[k]}, 32'd0);
        checkOutput($sformatf("u%0d idle out_stuff", k), {31'b0, out_stuff[k]}, 32'd0);
        checkOutput($sformatf("u%0d idle in_ready", k), {31'b0, in_ready[k]}, 32'd1);
        checkOutput($sformatf("u%0d idle busy", k), {31'b0, busy[k]}, 32'd0);
    endtask

    // One frame: one-cycle in_valid pulse, then drain and check the return
    // to idle on the cycle after the last line bit.
    task automatic applyStimulus(input int k, input logic [7:0] data,
                                 input logic [31:0] bits, input logic [31:0] stuffs,
                                 input int n);
        int h0;
        pushFrame(k, bits, stuffs, n);
        h0 = hs_count[k];
        tick();
        in_data     = data;
        in_valid[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0;
        waitDrain(k);
        tick();
        checkIdle(k);
        checkOutput($sformatf("u%0d handshakes per frame", k), hs_count[k] - h0, 32'd1);
    endtask

    initial begin
        int h0;
        int guard;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in_valid = 3'b000;
        in_data  = 8'h00;

        tick();
        tick();
        reset = 1'b0;

        for (int c = 0; c < 10; c++) begin
            tick();
            for (int k = 0; k < 3; k++) checkIdle(k);
        end

`ifdef SERIAL_STUFF_TX_PARITY_EN
        applyStimulus(0, 8'hAA, 32'b101010100, 32'b000000000, 9);
        applyStimulus(0, 8'hFF, 32'b1111101110, 32'b0000010000, 10);
        applyStimulus(1, 8'h00, 32'b0010010010010, 32'b0010010010010, 13);
        applyStimulus(1, 8'h03, 32'b0010010011010, 32'b0010010010100, 13);
        applyStimulus(2, 8'hA5, 32'b100110010110011001, 32'b010101010101010101, 18);
`else
        applyStimulus(0, 8'hAA, 32'b10101010, 32'b00000000, 8);
        applyStimulus(0, 8'hFF, 32'b111110111, 32'b000001000, 9);
        applyStimulus(1, 8'h00, 32'b001001001001, 32'b001001001001, 12);
        applyStimulus(1, 8'h03, 32'b001001001101, 32'b001001001010, 12);
        applyStimulus(2, 8'hA5, 32'b1001100101100110, 32'b0101010101010101, 16);
`endif

        // Abort 0xF0 with reset while its 4th bit is on the line.
        pushFrame(0, 32'b1111, 32'b0000, 4);
        tick();
        in_data     = 8'hF0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        waitDrain(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort out_valid", {31'b0, out_valid[0]}, 32'd0);
        checkOutput("abort busy", {31'b0, busy[0]}, 32'd0);
        checkOutput("abort in_ready", {31'b0, in_ready[0]}, 32'd1);

        // Fresh run after the abort: four zeros then four ones, no stuffing.
`ifdef SERIAL_STUFF_TX_PARITY_EN
        applyStimulus(0, 8'h0F, 32'b000011110, 32'b000000000, 9);
`else
        applyStimulus(0, 8'h0F, 32'b00001111, 32'b00000000, 8);
`endif

        // in_valid held high: exactly one handshake per frame, two frames.
`ifdef SERIAL_STUFF_TX_PARITY_EN
        pushFrame(1, 32'b0010010011010, 32'b0010010010100, 13);
        pushFrame(1, 32'b0010010011010, 32'b0010010010100, 13);
`else
        pushFrame(1, 32'b001001001101, 32'b001001001010, 12);
        pushFrame(1, 32'b001001001101, 32'b001001001010, 12);
`endif
        h0 = hs_count[1];
        tick();
        in_data     = 8'h03;
        in_valid[1] = 1'b1;
        guard = 0;
        while (hs_count[1] < h0 + 2 && guard < 100) begin
            tick();
            guard++;
        end
        in_valid[1] = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput("held valid bits pending", exp_q.size(), 32'd0);
        exp_q.delete();
        tick();
        checkIdle(1);
        checkOutput("held valid handshakes", hs_count[1] - h0, 32'd2);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
